decoder_3to8: RTL and testbench

- Registered 3-to-8 one-hot decoder with an input-valid qualifier.
- Each accepted 3-bit code produces a one-hot 8-bit word one clock later.
- Used as a small select/enable generator wherever a binary index must drive one of eight lines.
- Output is registered so downstream logic sees glitch-free, clock-aligned selects.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/decoder_if.sv | 13 +
 rtl/decoder_onehot_comb.sv | 21 ++
 rtl/decoder_3to8.sv | 47 ++++
 tb/tb_decoder_3to8.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared widths, code/one-hot types and a reference one-hot helper for the
// registered 3-to-8 decoder.
package decoder_pkg;

   localparam int DEC_IN_W  = 3;
   localparam int DEC_OUT_W = 8;

   typedef logic [DEC_IN_W-1:0]  dec_code_t;
   typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

   // Unsigned shift of a single 1 into the position named by the code.
   function automatic dec_onehot_t to_onehot(input dec_code_t code);
      dec_onehot_t result;
      result       = '0;
      result[code] = 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/decoder_if.sv
// Signal bundle used by the bench to reach the decoder; reset is carried as
// 'reset' and mapped onto the decoder's rst port at instantiation.
interface decoder_if;
   import decoder_pkg::*;

   logic        clk;
   logic        reset;
   logic        valid;
   dec_code_t   in;
   dec_onehot_t out;
   logic        out_valid;

endinterface

// File: rtl/decoder_onehot_comb.sv
// Combinational binary-to-one-hot stage feeding the decoder's output register.
// Each output line compares the code against its own index, so exactly one
// line is high for any defined code.
module decoder_onehot_comb
   import decoder_pkg::*;
#(
   parameter  int IN_W  = DEC_IN_W,
   localparam int OUT_W = 2 ** IN_W
) (
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] out
);

   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi = gi + 1) begin : g_line
         assign out[gi] = (in == IN_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with an input-valid qualifier.
// One cycle of latency, full throughput, asynchronous active-high reset.
// Build option: define DECODER_HOLD_EN to keep the last decode on out while
// valid is low; without it out clears to zero on every idle edge.
module decoder_3to8
   import decoder_pkg::*;
#(
   parameter  int IN_W  = DEC_IN_W,
   localparam int OUT_W = 2 ** IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] out,
   output logic             out_valid
);

   logic [OUT_W-1:0] decode_next;

   decoder_onehot_comb #(
      .IN_W (IN_W)
   ) u_onehot (
      .in  (in),
      .out (decode_next)
   );

   // Output register: reset clears at once; otherwise capture the decode
   // whenever valid is high, and track valid in out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid;
`ifdef DECODER_HOLD_EN
         if (valid) begin
            out <= decode_next;
         end
`else
         // Select zero when idle so an unknown code cannot leak through.
         out <= valid ? decode_next : '0;
`endif
      end
   end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: table-driven vectors through a
// scoreboard queue, plus hand-written reset sequences.
// Honours DECODER_HOLD_EN for the idle-cycle expectations.
module tb_decoder_3to8;
   import decoder_pkg::*;

   typedef struct {
      logic        valid;
      logic [2:0]  in;
      logic [7:0]  exp_out;
      logic        exp_valid;
      string       name;
   } vec_t;

   typedef struct {
      logic [7:0] exp_out;
      logic       exp_valid;
      string      name;
   } sb_t;

`ifdef DECODER_HOLD_EN
   localparam logic [7:0] IDLE_AFTER_SWEEP  = 8'h80;
   localparam logic [7:0] IDLE_AFTER_TOGGLE = 8'h04;
`else
   localparam logic [7:0] IDLE_AFTER_SWEEP  = 8'h00;
   localparam logic [7:0] IDLE_AFTER_TOGGLE = 8'h00;
`endif

   decoder_if dif ();

   decoder_3to8 dut (
      .clk       (dif.clk),
      .rst       (dif.reset),
      .valid     (dif.valid),
      .in        (dif.in),
      .out       (dif.out),
      .out_valid (dif.out_valid)
   );

   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];
   sb_t  sb_q[$];

   // Clock starts high so the first rising edge (t=10) follows reset release.
   initial begin
      dif.clk = 1'b1;
      forever #5 dif.clk = ~dif.clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [2:0] code, input logic [7:0] eo,
                      input logic ev, input string name);
      vec_t r;
      r.valid = v; r.in = code; r.exp_out = eo; r.exp_valid = ev; r.name = name;
      vecs.push_back(r);
   endtask

   task automatic push_exp(input logic [7:0] eo, input logic ev, input string name);
      sb_t e;
      e.exp_out = eo; e.exp_valid = ev; e.name = name;
      sb_q.push_back(e);
   endtask

   // Called at a falling edge after the rising edge that produced the output.
   task automatic pop_and_compare();
      sb_t e;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard: got empty queue required pending entry");
         return;
      end
      e = sb_q.pop_front();
      $display("[TB] %s valid=%b in=%h -> out=%h out_valid=%b", e.name, dif.valid, dif.in,
               dif.out, dif.out_valid);
      check({e.name, ".out"}, dif.out, e.exp_out);
      check({e.name, ".out_valid"}, {7'd0, dif.out_valid}, {7'd0, e.exp_valid});
      if (e.exp_valid) begin
         check({e.name, ".onehot"}, 8'($countones(dif.out)), 8'd1);
      end
   endtask

   initial begin
      // Reset held from time 0 with a valid code already on the inputs.
      dif.reset = 1'b1;
      dif.valid = 1'b1;
      dif.in    = 3'd3;
      #2;
      check("reset.out", dif.out, 8'h00);
      check("reset.out_valid", {7'd0, dif.out_valid}, 8'h00);
      #3;
      dif.reset = 1'b0;
      push_exp(8'h08, 1'b1, "post_reset");
      @(negedge dif.clk);
      pop_and_compare();

      // Exhaustive sweep, valid gating, valid toggling, unknown code, ramp.
      add(1'b1, 3'd0, 8'h01, 1'b1, "sweep0");
      add(1'b1, 3'd1, 8'h02, 1'b1, "sweep1");
      add(1'b1, 3'd2, 8'h04, 1'b1, "sweep2");
      add(1'b1, 3'd3, 8'h08, 1'b1, "sweep3");
      add(1'b1, 3'd4, 8'h10, 1'b1, "sweep4");
      add(1'b1, 3'd5, 8'h20, 1'b1, "sweep5");
      add(1'b1, 3'd6, 8'h40, 1'b1, "sweep6");
      add(1'b1, 3'd7, 8'h80, 1'b1, "sweep7");
      add(1'b0, 3'd5, IDLE_AFTER_SWEEP, 1'b0, "gate5");
      add(1'b1, 3'd2, 8'h04, 1'b1, "toggle_a1");
      add(1'b0, 3'd4, IDLE_AFTER_TOGGLE, 1'b0, "toggle_a0");
      add(1'b1, 3'd2, 8'h04, 1'b1, "toggle_b1");
      add(1'b0, 3'd4, IDLE_AFTER_TOGGLE, 1'b0, "toggle_b0");
      add(1'b0, 3'bxxx, IDLE_AFTER_TOGGLE, 1'b0, "unknown_in");
      for (int i = 0; i < 8; i++) begin
         add(1'b0, 3'(i), IDLE_AFTER_TOGGLE, 1'b0, $sformatf("ramp%0d", i));
      end

      foreach (vecs[k]) begin
         dif.valid = vecs[k].valid;
         dif.in    = vecs[k].in;
         push_exp(vecs[k].exp_out, vecs[k].exp_valid, vecs[k].name);
         @(negedge dif.clk);
         pop_and_compare();
      end

      // Mid-run reset: decode 6, then pulse rst between edges.
      dif.valid = 1'b1;
      dif.in    = 3'd6;
      push_exp(8'h40, 1'b1, "pre_reset6");
      @(negedge dif.clk);
      pop_and_compare();

      dif.valid = 1'b1;
      dif.in    = 3'd1;
      #2;
      dif.reset = 1'b1;
      #1;
      $display("[TB] midreset out=%h out_valid=%b", dif.out, dif.out_valid);
      check("midreset.out", dif.out, 8'h00);
      check("midreset.out_valid", {7'd0, dif.out_valid}, 8'h00);
      #1;
      dif.reset = 1'b0;
      push_exp(8'h02, 1'b1, "after_midreset1");
      @(negedge dif.clk);
      pop_and_compare();

      // Back to idle to finish.
      dif.valid = 1'b0;
      dif.in    = 3'd0;
      push_exp(8'h00 | ((IDLE_AFTER_SWEEP != 8'h00) ? 8'h02 : 8'h00), 1'b0, "final_idle");
      @(negedge dif.clk);
      pop_and_compare();

      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
